// File: rtl/timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller.
// Emits the one-hot beat vector W, the T3 end-of-beat strobe, and honours
// the controller's SHORT/LONG/STOP feedback plus the QD start button and
// DP single-step switch.
module timing_gen #(
    parameter  int TPH  = 4,
    parameter  int SYNC = 2,
    localparam int PW   = (TPH > 1) ? $clog2(TPH) : 1
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          QD,
    input  logic          DP,
    input  logic          SHORT,
    input  logic          LONG,
    input  logic          STOP,
    output logic [2:0]    W,
    output logic          T3,
    output logic          RUN,
    output logic          BEAT_END,
    output logic [PW-1:0] PH
);

    localparam logic [PW-1:0] LAST_PH = PW'(TPH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] ph;
    logic [PW-1:0] ph_next;
    logic [2:0]    w;
    logic [2:0]    w_next;
    logic [2:0]    w_after;
    logic [SYNC-1:0] sync;
    logic          qd_prev;
    logic          qd_edge;
    logic          beat_end;

    // Synchronise the asynchronous QD button and keep one delayed copy for edge detection.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            sync    <= '0;
            qd_prev <= 1'b0;
        end else begin
            sync    <= {sync[SYNC-2:0], QD};
            qd_prev <= sync[SYNC-1];
        end
    end

    // One-cycle pulse on a synchronised rising edge of QD; level holds give one pulse.
    always_comb begin
        qd_edge = sync[SYNC-1] & ~qd_prev;
    end

    // Beat end: last phase of a running beat.
    always_comb begin
        beat_end = (state == S_RUN) && (ph == LAST_PH);
    end

    // Beat to select after the current one; illegal encodings fall back to W1.
    always_comb begin
        w_after = 3'b001;
        unique case (w)
            3'b001:  w_after = SHORT ? 3'b001 : 3'b010;
            3'b010:  w_after = LONG  ? 3'b100 : 3'b001;
            default: w_after = 3'b001;
        endcase
    end

    // Next-state logic: start/resume on a QD edge, advance phases and beats while running.
    always_comb begin
        state_next = state;
        ph_next    = ph;
        w_next     = w;
        unique case (state)
            S_IDLE, S_HALT: begin
                if (qd_edge) begin
                    state_next = S_RUN;
                    ph_next    = '0;
                end
            end
            S_RUN: begin
                if (beat_end) begin
                    ph_next = '0;
                    w_next  = w_after;
                    if (STOP || DP) begin
                        state_next = S_HALT;
                    end
                end else begin
                    ph_next = ph + PW'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                ph_next    = '0;
                w_next     = 3'b001;
            end
        endcase
    end

    // State, phase and beat registers; CLR overrides everything and aborts any beat.
    always_ff @(posedge CLK) begin
        if (CLR) begin
            state <= S_IDLE;
            ph    <= '0;
            w     <= 3'b001;
        end else begin
            state <= state_next;
            ph    <= ph_next;
            w     <= w_next;
        end
    end

    // Output mapping.
    always_comb begin
        W        = w;
        PH       = ph;
        RUN      = (state == S_RUN);
        T3       = beat_end;
        BEAT_END = beat_end;
    end

endmodule

// File: tb/tb_timing_gen.sv
// Directed bench for timing_gen: a per-cycle table of inputs and expected
// outputs, followed by hand-written multi-cycle sequences.
module tb_timing_gen;

    logic       CLK;
    logic       CLR;
    logic       QD;
    logic       DP;
    logic       SHORT;
    logic       LONG;
    logic       STOP;
    logic [2:0] W;
    logic       T3;
    logic       RUN;
    logic       BEAT_END;
    logic [1:0] PH;

    timing_gen #(.TPH(4), .SYNC(2)) dut (
        .CLK      (CLK),
        .CLR      (CLR),
        .QD       (QD),
        .DP       (DP),
        .SHORT    (SHORT),
        .LONG     (LONG),
        .STOP     (STOP),
        .W        (W),
        .T3       (T3),
        .RUN      (RUN),
        .BEAT_END (BEAT_END),
        .PH       (PH)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Input bit map: {CLR, QD, DP, SHORT, LONG, STOP}
    localparam logic [5:0] N  = 6'b000000;
    localparam logic [5:0] CL = 6'b100000;
    localparam logic [5:0] Q  = 6'b010000;
    localparam logic [5:0] D  = 6'b001000;
    localparam logic [5:0] S  = 6'b000100;
    localparam logic [5:0] L  = 6'b000010;
    localparam logic [5:0] P  = 6'b000001;

    localparam logic [2:0] W1 = 3'b001;
    localparam logic [2:0] W2 = 3'b010;
    localparam logic [2:0] W3 = 3'b100;

    typedef struct {
        logic [5:0] in;
        logic [2:0] w;
        logic       t3;
        logic       run;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic add(input logic [5:0] i, input logic [2:0] w, input logic t3,
                       input logic run, input logic [1:0] ph);
        vec_t v;
        v.in = i; v.w = w; v.t3 = t3; v.run = run; v.ph = ph;
        vecs.push_back(v);
    endtask

    // Four running cycles of one beat; i0 is the input present at the previous beat end.
    task automatic beat(input logic [2:0] w, input logic [5:0] i0, input logic [5:0] i1,
                        input logic [5:0] i2, input logic [5:0] i3);
        add(i0, w, 1'b0, 1'b1, 2'd0);
        add(i1, w, 1'b0, 1'b1, 2'd1);
        add(i2, w, 1'b0, 1'b1, 2'd2);
        add(i3, w, 1'b1, 1'b1, 2'd3);
    endtask

    task automatic idle(input logic [5:0] i, input logic [2:0] w, input int n);
        for (int k = 0; k < n; k++) add(i, w, 1'b0, 1'b0, 2'd0);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    task automatic drive(input logic [5:0] i);
        {CLR, QD, DP, SHORT, LONG, STOP} = i;
    endtask

    initial begin
        int t3c;
        int w1c;
        int bad;
        logic seen_run;
        logic done;
        logic [2:0] exp_w;

        drive(CL);

        // Reset, start, plain W1/W2 alternation
        add(CL, W1, 1'b0, 1'b0, 2'd0);
        idle(Q, W1, 2);
        add(N, W1, 1'b0, 1'b1, 2'd0);
        add(N, W1, 1'b0, 1'b1, 2'd1);
        add(N, W1, 1'b0, 1'b1, 2'd2);
        add(N, W1, 1'b1, 1'b1, 2'd3);
        beat(W2, N, N, N, N);
        beat(W1, N, N, N, N);
        beat(W2, N, N, N, N);
        beat(W1, N, N, N, N);
        // SHORT held: W1 repeats; SHORT beats LONG; SHORT in W2 ignored
        beat(W1, S, S, S, S);
        beat(W1, S | L, S, S, S);
        beat(W2, N, N, N, N);
        beat(W1, S, N, N, N);
        // LONG: ignored in W1, honoured at W2 end, ignored in W3 and mid-W2
        beat(W2, L, N, N, N);
        beat(W3, L, N, N, N);
        beat(W1, S | L, N, N, N);
        beat(W2, N, N, L, N);
        beat(W1, N, N, N, N);
        // STOP at W1 end halts in W2; QD resumes a full W2 beat
        add(P, W2, 1'b0, 1'b0, 2'd0);
        idle(N, W2, 2);
        idle(Q, W2, 2);
        add(Q, W2, 1'b0, 1'b1, 2'd0);
        add(N, W2, 1'b0, 1'b1, 2'd1);
        add(N, W2, 1'b0, 1'b1, 2'd2);
        add(N, W2, 1'b1, 1'b1, 2'd3);
        beat(W1, N, N, N, N);
        // QD edge coincides with the halting beat end: ignored, held QD gives no new edge
        beat(W2, N, N, Q, Q);
        add(Q | P, W1, 1'b0, 1'b0, 2'd0);
        idle(Q, W1, 3);
        idle(N, W1, 2);
        // DP: QD held ~20 clocks gives one beat only
        idle(Q | D, W1, 2);
        add(Q | D, W1, 1'b0, 1'b1, 2'd0);
        add(Q | D, W1, 1'b0, 1'b1, 2'd1);
        add(Q | D, W1, 1'b0, 1'b1, 2'd2);
        add(Q | D, W1, 1'b1, 1'b1, 2'd3);
        add(Q | D, W2, 1'b0, 1'b0, 2'd0);
        idle(Q | D, W2, 14);
        idle(D, W2, 2);
        // DP: a second QD edge arriving mid-beat is dropped, not queued
        add(D | Q, W2, 1'b0, 1'b0, 2'd0);
        add(D, W2, 1'b0, 1'b0, 2'd0);
        add(D, W2, 1'b0, 1'b1, 2'd0);
        add(D | Q, W2, 1'b0, 1'b1, 2'd1);
        add(D, W2, 1'b0, 1'b1, 2'd2);
        add(D, W2, 1'b1, 1'b1, 2'd3);
        add(D, W1, 1'b0, 1'b0, 2'd0);
        idle(D, W1, 3);
        // CLR at W2 PH=2 aborts the beat without T3; QD restarts in W1
        idle(Q, W1, 2);
        add(N, W1, 1'b0, 1'b1, 2'd0);
        add(N, W1, 1'b0, 1'b1, 2'd1);
        add(N, W1, 1'b0, 1'b1, 2'd2);
        add(N, W1, 1'b1, 1'b1, 2'd3);
        add(N, W2, 1'b0, 1'b1, 2'd0);
        add(N, W2, 1'b0, 1'b1, 2'd1);
        add(N, W2, 1'b0, 1'b1, 2'd2);
        add(CL, W1, 1'b0, 1'b0, 2'd0);
        idle(N, W1, 2);
        idle(Q, W1, 2);
        add(N, W1, 1'b0, 1'b1, 2'd0);
        add(N, W1, 1'b0, 1'b1, 2'd1);
        add(N, W1, 1'b0, 1'b1, 2'd2);
        add(N, W1, 1'b1, 1'b1, 2'd3);
        beat(W2, N, N, N, N);

        for (int k = 0; k < vecs.size(); k++) begin
            drive(vecs[k].in);
            tick();
            total_cnt++;
            if ({W, T3, RUN, PH, BEAT_END} ===
                {vecs[k].w, vecs[k].t3, vecs[k].run, vecs[k].ph, vecs[k].t3}) begin
                pass_cnt++;
            end else begin
                $display("FAIL row%0d: got W=%b T3=%b RUN=%b PH=%0d BE=%b, want W=%b T3=%b RUN=%b PH=%0d BE=%b",
                         k, W, T3, RUN, PH, BEAT_END,
                         vecs[k].w, vecs[k].t3, vecs[k].run, vecs[k].ph, vecs[k].t3);
            end
        end

        // Free-running: 24 clocks from W1 PH=0 are six 4-clock beats alternating W1/W2
        drive(N);
        t3c = 0; w1c = 0; bad = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (T3) t3c++;
            if (W == W1) w1c++;
            if (BEAT_END !== T3 || !(W == W1 || W == W2 || W == W3) || RUN !== 1'b1) bad++;
        end
        chk("free_run_t3_count", t3c, 6);
        chk("free_run_w1_cycles", w1c, 12);
        chk("free_run_bad_cycles", bad, 0);

        // Single-step: each QD press gives exactly one beat and one T3
        drive(D);
        tick();
        chk("dp_halt_run", int'(RUN), 0);
        chk("dp_halt_w", int'(W), int'(W1));
        exp_w = W2;
        for (int p = 0; p < 3; p++) begin
            drive(D | Q);
            tick();
            tick();
            drive(D);
            t3c = 0; seen_run = 1'b0; done = 1'b0;
            for (int c = 0; c < 20 && !done; c++) begin
                tick();
                if (T3) t3c++;
                if (RUN) seen_run = 1'b1;
                else if (seen_run) done = 1'b1;
            end
            chk("dp_step_done", int'(done), 1);
            chk("dp_step_t3", t3c, 1);
            chk("dp_step_w", int'(W), int'(exp_w));
            exp_w = (exp_w == W2) ? W1 : W2;
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got running, want finished");
        $fatal(1);
    end

endmodule

// File: doc/timing_gen.md
Name: timing_gen

Overview:
- Beat/phase timing generator directly upstream of the hardwired controller.
- Produces the one-hot beat vector W[3:1] and the T3 end-of-beat strobe that the controller consumes.
- Consumes the controller's SHORT/LONG/STOP feedback to shorten, lengthen or halt the machine cycle.
- Handles the start button (QD) and the single-step switch (DP).

Parameters:
TPH, 4, clock phases per beat (minimum 2); T3 is asserted in the last phase.
SYNC, 2, synchronizer depth for the QD input (minimum 2).

Ports:
CLK  in  1  system clock, all state on rising edge
CLR  in  1  reset, synchronous, active-high
QD  in  1  start/continue button, asynchronous, level
DP  in  1  single-step mode, static level; sampled at beat end
SHORT  in  1  from controller: skip W2 (honoured only in W1)
LONG  in  1  from controller: insert W3 (honoured only in W2)
STOP  in  1  from controller: halt after current beat
W  out  3  one-hot beat, bit0=W1, bit1=W2, bit2=W3
T3  out  1  end-of-beat strobe, high for last phase of a running beat
RUN  out  1  1 while beats are advancing
BEAT_END  out  1  single-cycle pulse, equals T3 (one cycle wide since T3 lasts one phase = one clock)
PH  out  clog2(TPH)  current phase index, for debug

Behaviour:
- Reset: CLR sampled high on a rising CLK edge. Next cycle: W=3'b001, PH=0, T3=0, RUN=0, BEAT_END=0, state=IDLE, synchronizer flops=0. Reset mid-beat aborts the beat immediately; no T3 is emitted.
- States: IDLE (after reset), RUN, HALT. IDLE and HALT behave identically except for the W value held.
- QD path:
  - SYNC-stage synchronizer, then a rising-edge detector (one extra flop).
  - Edge pulse is one cycle. With SYNC=2, RUN rises on the 3rd rising CLK edge after QD is first sampled high.
  - QD held high generates exactly one edge.
  - Edges seen while RUN=1 are ignored and not queued.
- IDLE/HALT + QD edge: go to RUN with PH=0; W is unchanged (resume with the beat already selected).
- RUN:
  - PH increments each cycle, modulo TPH.
  - T3=1 exactly when PH==TPH-1; T3=0 in every other phase and whenever RUN=0.
- Beat end (RUN && PH==TPH-1), next W:
  - W1: SHORT ? W1 : W2
  - W2: LONG ? W3 : W1
  - W3: W1 (SHORT and LONG ignored)
- SHORT in W2/W3 and LONG in W1/W3 are ignored. SHORT and LONG both high in W1: SHORT wins (W2 is skipped, so LONG is moot).
- Halt: at beat end, if STOP||DP, W still advances per the rule above, PH returns to 0 and the state goes to HALT (RUN=0 next cycle). Otherwise stay in RUN with PH=0.
- Sampling window: SHORT/LONG/STOP/DP are sampled only at beat end. Pulses in other phases have no effect.
- A QD edge on the same cycle as the halting beat end is ignored; the next edge is required.
- CLR has priority over every other event.
- W is never zero and never multi-hot; any illegal value (unreachable) recovers to W1 at the next beat end.
- Beat length is exactly TPH clocks. Machine cycle: 2 beats (W1,W2), 1 beat (SHORT) or 3 beats (LONG).

Test Plan:
1. Reset then QD pulse; SHORT=LONG=STOP=DP=0, TPH=4 -> RUN rises 3 clocks after QD. W sequence 001,010,001,010… each held 4 clocks. T3 high in cycles PH=3 only.
2. SHORT=1 constant -> W stays 001 every beat; T3 every 4 clocks; W2 never appears.
3. LONG asserted only during W2 phase 3 -> W sequence 001,010,100,001. LONG pulsed during W2 phase 1 only -> no W3.
4. STOP=1 in W1 beat end -> W=010, RUN=0, T3 stays 0, PH=0. QD edge resumes in W2; the W2 beat runs 4 clocks.
5. DP=1 -> exactly one T3 per QD edge. QD held high for 20 clocks yields one beat only. QD edge during RUN is ignored.
6. CLR asserted at W2 PH=2 while running -> next cycle W=001, PH=0, RUN=0, no T3 emitted. A subsequent QD restarts in W1.
